icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
//  Instruction-cache controller: drives the 8-line direct-mapped 64-bit-line cache array from the fetch side.
//  Looks up each fetch, returns the 16-bit word on a hit, and refills the line from main memory on a miss.
//  Main memory has a fixed 4-cycle read latency and no ready strobe; the controller times it.
//  Sits between the IF stage (pc/fetch_req/instr/instr_vld) and the cache array plus main memory.
// PARAMETERS
//  MEM_LAT   4   main-memory read latency in cycles, m_re high to m_rd_data valid (legal 1..15)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active high
//  pc           in   16  word address of fetch
//  fetch_req    in   1   fetch request, held until instr_vld
//  instr        out  16  fetched instruction, valid when instr_vld
//  instr_vld    out  1   instruction returned this cycle; IF stalls while fetch_req & ~instr_vld
//  c_addr       out  14  cache line address = {tag[10:0],index[2:0]}
//  c_re         out  1   cache read enable
//  c_we         out  1   cache write enable (refill)
//  c_wr_data    out  64  refill line
//  c_wdirty     out  1   dirty bit to write; always 0 (I-cache lines never dirty)
//  c_rd_data    in   64  cache line read out
//  c_hit        in   1   tag match & valid, same cycle as c_re
//  m_addr       out  14  main-memory line address
//  m_re         out  1   main-memory read enable
//  m_rd_data    in   64  main-memory line, valid in final cycle of a read
//  miss_cnt     out  16  saturating count of refills since reset
// BEHAVIOUR
//  Address split: line = pc[15:2]; index = pc[4:2]; tag = pc[15:5]; word sel = pc[1:0].
//  Word select: instr = c_rd_data[16*pc[1:0] +: 16] (word 0 in [15:0]); 0 when not instr_vld.
//  States: IDLE, MEM_RD, FILL. Reset: state IDLE, lat_cnt 0, miss_addr 0, fill_buf 0, miss_cnt 0;
//   all outputs 0 during and after reset (c_wdirty tied 0).
//  IDLE: c_addr = pc[15:2]; c_re = fetch_req.
//   fetch_req & c_hit  -> instr_vld = 1 same cycle (1-cycle hit), stay IDLE; back-to-back hits every cycle.
//   fetch_req & ~c_hit -> miss_addr <= pc[15:2], lat_cnt <= 0, -> MEM_RD.
//   ~fetch_req         -> c_re = 0, instr_vld = 0, stay IDLE.
//  MEM_RD: m_re = 1, m_addr = miss_addr, c_re = 0, instr_vld = 0; lat_cnt increments each cycle.
//   lat_cnt == MEM_LAT-1: fill_buf <= m_rd_data, -> FILL. m_re high exactly MEM_LAT cycles.
//  FILL: c_we = 1 for exactly one cycle, c_addr = miss_addr, c_wr_data = fill_buf; miss_cnt += 1 (saturate at 16'hFFFF);
//   -> IDLE. Next IDLE cycle re-looks-up pc; refilled line hits.
//  Miss penalty: miss cycle + MEM_LAT + FILL + hit cycle = MEM_LAT+3 cycles from first request to instr_vld (7 at default).
//  pc/fetch_req changes during MEM_RD/FILL are ignored; refill of miss_addr always completes.
//  fetch_req deasserted mid-miss: refill completes, no instr_vld, return IDLE.
//  New pc after refill that maps to same index, different tag: ordinary miss, evicts (no writeback; lines never dirty).
//  c_we and c_re never high in the same cycle; m_re never high outside MEM_RD.
//  rst mid-miss: abort next edge, state IDLE, m_re/c_we drop to 0, partial refill discarded.
// TESTING
//  Reset, then fetch pc=16'h0000 (cold) -> m_re 4 cycles with m_addr=0, c_we 1 cycle, instr_vld 7 cycles after request, miss_cnt=1.
//  Then pc=0x0001,0x0002,0x0003 back-to-back -> instr_vld 3 consecutive cycles, words 1..3 of line, no m_re, miss_cnt=1.
//  pc=0x0020 (index 0, tag 1) -> miss, evicts line 0; then pc=0x0000 -> miss again; miss_cnt=3.
//  fetch_req dropped in 2nd MEM_RD cycle -> refill completes, c_we pulses, no instr_vld; later fetch of same pc hits in 1 cycle.
//  rst asserted in 3rd MEM_RD cycle -> next cycle m_re=0, c_we never pulses, miss_cnt=0, later fetch misses.
//  MEM_LAT=1 build: miss penalty 4 cycles; force miss_cnt near 16'hFFFF -> saturates, no wrap.

Source files
------------

// File: rtl/icache_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : icache_if
// Purpose  : Fetch-side, cache-array and main-memory signals of the I-cache
//            controller, grouped with controller (master) / environment
//            (slave) views.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface icache_if;
    logic [15:0] pc;
    logic        fetch_req;
    logic [15:0] instr;
    logic        instr_vld;
    logic [13:0] c_addr;
    logic        c_re;
    logic        c_we;
    logic [63:0] c_wr_data;
    logic        c_wdirty;
    logic [63:0] c_rd_data;
    logic        c_hit;
    logic [13:0] m_addr;
    logic        m_re;
    logic [63:0] m_rd_data;
    logic [15:0] miss_cnt;

    modport master (
        input  pc, fetch_req, c_rd_data, c_hit, m_rd_data,
        output instr, instr_vld, c_addr, c_re, c_we, c_wr_data, c_wdirty,
               m_addr, m_re, miss_cnt
    );

    modport slave (
        output pc, fetch_req, c_rd_data, c_hit, m_rd_data,
        input  instr, instr_vld, c_addr, c_re, c_we, c_wr_data, c_wdirty,
               m_addr, m_re, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : icache_ctrl
// Purpose  : Direct-mapped I-cache controller: 1-cycle hits, timed refill
//            from fixed-latency main memory on a miss.
// Revision : 1.0
// ---------------------------------------------------------------------------
module icache_ctrl #(
    parameter int MEM_LAT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    icache_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        FILL   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    state_t      state;
    logic [3:0]  lat_cnt;
    logic [13:0] miss_addr;
    logic [63:0] fill_buf;
    logic [15:0] miss_count;
    logic [15:0] miss_count_nxt;

    logic        in_idle;
    logic        in_mem_rd;
    logic        in_fill;
    logic        hit_now;
    logic [15:0] word_sel;

    // Outputs are gated by rst so nothing leaks out during the reset cycle.
    assign in_idle   = (state == IDLE)   && !rst;
    assign in_mem_rd = (state == MEM_RD) && !rst;
    assign in_fill   = (state == FILL)   && !rst;
    assign hit_now   = in_idle && bus.fetch_req && bus.c_hit;
    assign word_sel  = bus.c_rd_data[{bus.pc[1:0], 4'b0000} +: 16];

    assign miss_count_nxt = (state == FILL && miss_count != 16'hFFFF)
                            ? miss_count + 16'd1 : miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            miss_addr  <= 14'd0;
            fill_buf   <= 64'd0;
            miss_count <= 16'd0;
        end else begin
            miss_count <= miss_count_nxt;
            case (state)
                IDLE: begin
                    if (bus.fetch_req && !bus.c_hit) begin
                        miss_addr <= bus.pc[15:2];
                        lat_cnt   <= 4'd0;
                        state     <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    // Memory has no ready strobe: data is valid only in the last latency cycle.
                    if (lat_cnt == LAT_LAST) begin
                        fill_buf <= bus.m_rd_data;
                        state    <= FILL;
                    end
                end
                FILL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.c_re      = in_idle && bus.fetch_req;
    assign bus.instr_vld = hit_now;
    assign bus.instr     = hit_now ? word_sel : 16'd0;
    assign bus.c_addr    = in_fill ? miss_addr : (in_idle ? bus.pc[15:2] : 14'd0);
    assign bus.c_we      = in_fill;
    assign bus.c_wr_data = in_fill ? fill_buf : 64'd0;
    assign bus.c_wdirty  = 1'b0;
    assign bus.m_re      = in_mem_rd;
    assign bus.m_addr    = in_mem_rd ? miss_addr : 14'd0;
    assign bus.miss_cnt  = rst ? 16'd0 : miss_count;

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : tb_icache_ctrl
// Purpose  : Scoreboard bench for icache_ctrl (MEM_LAT=4 main instance,
//            MEM_LAT=1 instance for short penalty and counter saturation).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_icache_ctrl;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    icache_if bus_a ();
    icache_if bus_b ();

    icache_ctrl #(.MEM_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst),   .bus(bus_a));
    icache_ctrl #(.MEM_LAT(LAT_B)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main-memory contents: every line and word distinguishable.
    function automatic logic [63:0] mem_line(input logic [13:0] a);
        return {2'b11, a, 2'b10, ~a, 2'b01, a ^ 14'h1555, 2'b00, a + 14'h0123};
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] p);
        logic [63:0] ln;
        ln = mem_line(p[15:2]);
        return ln[int'(p[1:0]) * 16 +: 16];
    endfunction

    // ---------------- environment: cache arrays + memory with fixed latency ----
    logic [10:0] arr_tag_a [8] = '{default: '0};
    logic        arr_val_a [8] = '{default: 1'b0};
    logic [63:0] arr_dat_a [8] = '{default: '0};
    logic [10:0] arr_tag_b [8] = '{default: '0};
    logic        arr_val_b [8] = '{default: 1'b0};
    logic [63:0] arr_dat_b [8] = '{default: '0};
    int m_cnt_a = 0;
    int m_cnt_b = 0;

    always_comb begin
        bus_a.c_hit     = bus_a.c_re && arr_val_a[bus_a.c_addr[2:0]]
                          && (arr_tag_a[bus_a.c_addr[2:0]] == bus_a.c_addr[13:3]);
        bus_a.c_rd_data = bus_a.c_re ? arr_dat_a[bus_a.c_addr[2:0]] : 64'd0;
        bus_a.m_rd_data = (bus_a.m_re && m_cnt_a == LAT_A - 1) ? mem_line(bus_a.m_addr)
                                                               : 64'hBAD0_BAD0_BAD0_BAD0;
        bus_b.c_hit     = bus_b.c_re && arr_val_b[bus_b.c_addr[2:0]]
                          && (arr_tag_b[bus_b.c_addr[2:0]] == bus_b.c_addr[13:3]);
        bus_b.c_rd_data = bus_b.c_re ? arr_dat_b[bus_b.c_addr[2:0]] : 64'd0;
        bus_b.m_rd_data = (bus_b.m_re && m_cnt_b == LAT_B - 1) ? mem_line(bus_b.m_addr)
                                                               : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(posedge clk) begin
        if (bus_a.c_we) begin
            arr_val_a[bus_a.c_addr[2:0]] <= 1'b1;
            arr_tag_a[bus_a.c_addr[2:0]] <= bus_a.c_addr[13:3];
            arr_dat_a[bus_a.c_addr[2:0]] <= bus_a.c_wr_data;
        end
        if (bus_b.c_we) begin
            arr_val_b[bus_b.c_addr[2:0]] <= 1'b1;
            arr_tag_b[bus_b.c_addr[2:0]] <= bus_b.c_addr[13:3];
            arr_dat_b[bus_b.c_addr[2:0]] <= bus_b.c_wr_data;
        end
        m_cnt_a <= bus_a.m_re ? m_cnt_a + 1 : 0;
        m_cnt_b <= bus_b.m_re ? m_cnt_b + 1 : 0;
    end

    // ---------------- reference model: which lines are resident, refill count --
    logic [10:0] ref_tag [8] = '{default: '0};
    logic        ref_val [8] = '{default: 1'b0};
    int          ref_miss = 0;

    task automatic ref_lookup(input logic [15:0] p, output bit hit);
        hit = ref_val[p[4:2]] && (ref_tag[p[4:2]] == p[15:5]);
        if (!hit) begin
            ref_val[p[4:2]] = 1'b1;
            ref_tag[p[4:2]] = p[15:5];
            if (ref_miss < 16'hFFFF) ref_miss++;
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic [15:0] mcnt;
        int          issue;
    } exp_t;
    exp_t sb[$];

    // ---------------- monitor -------------------------------------------------
    int we_cnt_a = 0;
    int m_run_a  = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_run_a = 0;
        end else begin
            if (bus_a.instr_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_vld", 64'(bus_a.instr_vld), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("instr", 64'(bus_a.instr), 64'(e.instr));
                    chk("latency", 64'(cyc - e.issue + 1), 64'(e.lat));
                    chk("miss_cnt", 64'(bus_a.miss_cnt), 64'(e.mcnt));
                end
            end
            if (bus_a.c_we) begin
                we_cnt_a++;
                chk("fill_data", bus_a.c_wr_data, mem_line(bus_a.c_addr));
                chk("we_re_excl", 64'(bus_a.c_re), 64'd0);
            end
            if (bus_a.m_re) begin
                m_run_a++;
            end else if (m_run_a != 0) begin
                chk("m_re_len", 64'(m_run_a), 64'(LAT_A));
                m_run_a = 0;
            end
        end
    end

    // ---------------- stimulus tasks -------------------------------------------
    task automatic fetch(input logic [15:0] p);
        bit   hit;
        bit   seen;
        exp_t e;
        ref_lookup(p, hit);
        e.instr = mem_word(p);
        e.lat   = hit ? 1 : LAT_A + 3;
        e.mcnt  = 16'(ref_miss);
        e.issue = cyc;
        sb.push_back(e);
        bus_a.pc        = p;
        bus_a.fetch_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.instr_vld) seen = 1'b1;
        end
        if (!seen) chk("vld_timeout", 64'(seen), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle_a(input int n);
        bus_a.fetch_req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic b_fetch(input logic [15:0] p, input int exp_lat, input logic [15:0] exp_cnt);
        int n;
        bus_b.pc        = p;
        bus_b.fetch_req = 1'b1;
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            @(negedge clk);
            if (bus_b.instr_vld) n = i;
        end
        chk("b_latency", 64'(n), 64'(exp_lat));
        chk("b_instr", 64'(bus_b.instr), 64'(mem_word(p)));
        chk("b_miss_cnt", 64'(bus_b.miss_cnt), 64'(exp_cnt));
        @(posedge clk); #1;
        bus_b.fetch_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  we0;
        bit  hit;
        logic [15:0] p;
        rst             = 1'b1;
        rst_b           = 1'b1;
        bus_a.pc        = 16'h1234;
        bus_a.fetch_req = 1'b1;
        bus_b.pc        = 16'h0;
        bus_b.fetch_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_vld", 64'(bus_a.instr_vld), 64'd0);
        chk("rst_c_re", 64'(bus_a.c_re), 64'd0);
        chk("rst_c_we", 64'(bus_a.c_we), 64'd0);
        chk("rst_m_re", 64'(bus_a.m_re), 64'd0);
        chk("rst_c_addr", 64'(bus_a.c_addr), 64'd0);
        chk("rst_instr", 64'(bus_a.instr), 64'd0);
        chk("rst_miss_cnt", 64'(bus_a.miss_cnt), 64'd0);
        chk("rst_c_wdirty", 64'(bus_a.c_wdirty), 64'd0);
        @(posedge clk); #1;
        rst             = 1'b0;
        rst_b           = 1'b0;
        bus_a.fetch_req = 1'b0;
        idle_a(2);

        // Cold miss, back-to-back hits, conflict eviction
        fetch(16'h0000);
        fetch(16'h0001);
        fetch(16'h0002);
        fetch(16'h0003);
        fetch(16'h0020);
        fetch(16'h0000);
        idle_a(1);
        chk("miss_cnt_after_evict", 64'(bus_a.miss_cnt), 64'd3);

        // fetch_req dropped in the second memory-read cycle
        p = 16'h0044;
        ref_lookup(p, hit);
        we0 = we_cnt_a;
        bus_a.pc = p; bus_a.fetch_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_a.fetch_req = 1'b0; bus_a.pc = 16'hFFFF;
        repeat (LAT_A) begin @(posedge clk); #1; end
        chk("drop_we_pulses", 64'(we_cnt_a - we0), 64'd1);
        chk("drop_miss_cnt", 64'(bus_a.miss_cnt), 64'(ref_miss));
        fetch(16'h0045);
        idle_a(1);

        // Reset in the third memory-read cycle aborts the refill
        p = 16'h0088;
        bus_a.pc = p; bus_a.fetch_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        we0 = we_cnt_a;
        rst = 1'b1; bus_a.fetch_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_m_re", 64'(bus_a.m_re), 64'd0);
        chk("abort_miss_cnt", 64'(bus_a.miss_cnt), 64'd0);
        ref_miss = 0;
        repeat (LAT_A + 2) begin @(posedge clk); #1; end
        chk("abort_we_pulses", 64'(we_cnt_a - we0), 64'd0);
        fetch(p);

        // Random fetch stream over a small footprint to mix hits and conflicts
        for (int k = 0; k < 80; k++) begin
            p = {9'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            fetch(p);
            if ($urandom_range(0, 3) == 0) idle_a(1 + $urandom_range(0, 1));
        end
        idle_a(2);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // MEM_LAT=1 instance: 4-cycle miss penalty and saturating refill count
        b_fetch(16'h0100, LAT_B + 3, 16'd1);
        b_fetch(16'h0101, 1, 16'd1);
        force dut_b.miss_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut_b.miss_count;
        @(posedge clk); #1;
        chk("b_forced_cnt", 64'(bus_b.miss_cnt), 64'hFFFE);
        b_fetch(16'h0120, LAT_B + 3, 16'hFFFF);
        b_fetch(16'h0100, LAT_B + 3, 16'hFFFF);
        b_fetch(16'h0102, 1, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
